fifo_stack: RTL and testbench

Synchronous single-clock byte FIFO used as a buffering stage in the USB3300 parser datapath. Producer logic writes one word per clock while `save` is high. Consumer logic reads the oldest word and releases it with `pop`. `full` and `empty` status flags provide flow control to both sides.

---
 rtl/fifo_stack.sv | 68 ++++++
 tb/tb_fifo_stack.sv | 103 ++++++++++
 2 files changed

// File: rtl/fifo_stack.sv
// Single-clock byte FIFO with first-word fall-through output and full/empty flags.
// A write into a full FIFO is accepted only when a pop frees a slot on the same edge.
module fifo_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] I_DATA,
    input  logic                  save,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] O_DATA,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]    count_q, count_d;
    logic                  wr_ok;
    logic                  rd_ok;

    always_comb begin
        full  = (count_q == (ADDR_BITS + 1)'(DEPTH));
        empty = (count_q == '0);
        rd_ok = pop && !empty;
        wr_ok = save && (!full || rd_ok);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_ok) begin
            mem_d[wr_ptr_q] = I_DATA;
            wr_ptr_d        = wr_ptr_q + ADDR_BITS'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + (ADDR_BITS + 1)'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - (ADDR_BITS + 1)'(1);
        end

        O_DATA = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Memory is left untouched by reset; clearing the pointers is enough to discard it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_fifo_stack.sv
// Directed bench for fifo_stack; a queue scoreboard holds the words expected at the output.
module tb_fifo_stack;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] I_DATA;
    logic       save;
    logic       pop;
    logic [7:0] O_DATA;
    logic       full;
    logic       empty;

    logic [7:0] sb[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    fifo_stack #(.DATA_WIDTH(8), .ADDR_BITS(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .I_DATA (I_DATA),
        .save   (save),
        .pop    (pop),
        .O_DATA (O_DATA),
        .full   (full),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    // Compare all three outputs against the scoreboard head and occupancy.
    task automatic checkOutput(input string tag);
        logic [7:0] exp_data;
        logic       exp_full;
        logic       exp_empty;
        exp_data  = (sb.size() > 0) ? sb[0] : 8'h00;
        exp_full  = (sb.size() == 8);
        exp_empty = (sb.size() == 0);
        total_cnt++;
        assert (O_DATA === exp_data) pass_cnt++;
        else $error("[TB] FAIL %s O_DATA got %02h expected %02h", tag, O_DATA, exp_data);
        total_cnt++;
        assert (full === exp_full) pass_cnt++;
        else $error("[TB] FAIL %s full got %b expected %b", tag, full, exp_full);
        total_cnt++;
        assert (empty === exp_empty) pass_cnt++;
        else $error("[TB] FAIL %s empty got %b expected %b", tag, empty, exp_empty);
    endtask

    // Drive one cycle, update the scoreboard for that edge, then check just after it.
    task automatic applyStimulus(input logic r, input logic s, input logic p,
                                 input logic [7:0] d, input string tag);
        logic rd_acc;
        logic wr_acc;
        reset  = r;
        save   = s;
        pop    = p;
        I_DATA = d;
        @(posedge clk);
        if (!r) begin
            sb.delete();
        end else begin
            rd_acc = p && (sb.size() > 0);
            wr_acc = s && ((sb.size() < 8) || rd_acc);
            if (rd_acc) void'(sb.pop_front());
            if (wr_acc) sb.push_back(d);
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [7:0] hola [8];
        hola = '{8'h48, 8'h6F, 8'h6C, 8'h61, 8'h20, 8'h55, 8'h53, 8'h42};

        applyStimulus(1'b0, 1'b1, 1'b0, 8'hAA, "reset0");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hAB, "reset1");

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, hola[i], "fill");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, "overflow");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "idle_full");

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, "drain");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, "underflow");

        applyStimulus(1'b1, 1'b1, 1'b1, 8'h01, "both_empty");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h02, "pre2");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h03, "pre3");
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1, 8'h10 + 8'(i), "stream");

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h30 + 8'(i), "refill");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE, "both_full");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, "drain2");

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h60 + 8'(i), "pre_reset");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h77, "mid_reset");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h41, "after_reset");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, "final_pop");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
